// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and adder slice width.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/adder_seq_16bit_if.sv
// Request/result bundle of the nibble-serial adder; master drives operands, slave returns results.
interface adder_seq_16bit_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );

endinterface

// File: rtl/adder_seq_16bit_rca.sv
// Combinational 4-bit ripple-carry adder slice reused on every nibble pass.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic       c_out,
  output logic [3:0] sum
);

  always_comb begin
    logic carry;
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/adder_seq_16bit.sv
// Sequential adder: one 4-bit ripple slice time-multiplexed over the operand nibbles, LSB first.
module adder_seq_16bit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NIBBLES = WIDTH / 4
) (
  input logic              clk,
  input logic              rst,
  adder_seq_16bit_if.slave bus
);

  localparam int unsigned     IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                c_out_q, c_out_d;
  logic                ovf_q, ovf_d;

  int unsigned         nib_lsb;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  assign nib_lsb = NIBBLE_W * 32'(idx_q);
  assign nib_a   = a_q[nib_lsb +: NIBBLE_W];
  assign nib_b   = b_q[nib_lsb +: NIBBLE_W];

  ripple_carry_adder_4bit u_rca (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .c_out (nib_cout),
    .sum   (nib_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d[nib_lsb +: NIBBLE_W] = nib_sum;
        carry_d                     = nib_cout;
        if (idx_q == LastIdx) begin
          // Publish from work_d so the final nibble is included on this same edge.
          state_d = StDone;
          sum_d   = work_d;
          c_out_d = nib_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adder_seq_16bit.sv
// Directed and random checks of the nibble-serial adder against a plain-arithmetic model.
module tb_adder_seq_16bit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Last published result, used to check that outputs hold while busy.
  logic [15:0] r_sum  = '0;
  logic        r_cout = 1'b0;
  logic        r_ovf  = 1'b0;

  adder_seq_16bit_if #(.WIDTH(16)) bus ();

  adder_seq_16bit #(.WIDTH(16), .NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic busy_e, input logic done_e);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy_e));
    chk({tag, ".done"}, 32'(bus.done), 32'(done_e));
    chk({tag, ".sum"}, 32'(bus.sum), 32'(r_sum));
    chk({tag, ".c_out"}, 32'(bus.c_out), 32'(r_cout));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(r_ovf));
  endtask

  // Issue one operation, disturb inputs while it runs, and verify timing and result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci);
    logic [16:0] full;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    tick();
    full = {1'b0, a} + {1'b0, b} + 17'(ci);
    for (int i = 0; i < 4; i++) begin
      check_outputs({tag, ".run"}, 1'b1, 1'b0);
      if (i == 0) begin
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0001;
        bus.c_in  = 1'b1;
      end else begin
        bus.start = 1'($urandom);
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.c_in  = 1'($urandom);
      end
      tick();
    end
    bus.start = 1'b0;
    r_sum  = full[15:0];
    r_cout = full[16];
    r_ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    check_outputs({tag, ".done"}, 1'b0, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_outputs("reset", 1'b0, 1'b0);
    tick();
    check_outputs("idle", 1'b0, 1'b0);

    do_op("basic", 16'h1234, 16'h4321, 1'b0);
    chk("basic.value", 32'(bus.sum), 32'h5555);
    tick();
    check_outputs("after_done", 1'b0, 1'b0);

    do_op("carry_all", 16'hFFFF, 16'h0001, 1'b0);
    chk("carry_all.value", {15'd0, bus.c_out, bus.sum}, 32'h1_0000);
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    chk("pos_ovf.flag", 32'(bus.overflow), 32'd1);
    do_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    chk("all_ones.value", {15'd0, bus.c_out, bus.sum}, 32'h1_FFFF);
    do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0);

    // Start noise during RUN must not disturb the 1+1 result; back-to-back start from DONE.
    do_op("ignore", 16'h0001, 16'h0001, 1'b0);
    chk("ignore.value", 32'(bus.sum), 32'h0002);
    do_op("b2b", 16'h00FF, 16'h0001, 1'b0);
    chk("b2b.value", 32'(bus.sum), 32'h0100);
    tick();

    // Reset during the second RUN cycle aborts with no done pulse and clears the result.
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h1111;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    r_sum  = '0;
    r_cout = 1'b0;
    r_ovf  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_outputs("abort", 1'b0, 1'b0);
      tick();
    end

    // Reset wins over a simultaneous start.
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check_outputs("rst_prio", 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check_outputs("rand_idle", 1'b0, 1'b0);
      end
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    end
    tick();
    check_outputs("final_idle", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
